// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared defaults, address width and loader state encoding
package imem_pkg;

    localparam int DEFAULT_INSTRUCT_SIZE = 4;
    localparam int DEFAULT_NUM_INSTRUCTS = 512;
    localparam int AW = $clog2(DEFAULT_NUM_INSTRUCTS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - instruction stream input and memory write port bundle
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int INSTRUCT_SIZE = DEFAULT_INSTRUCT_SIZE,
    parameter int NUM_INSTRUCTS = DEFAULT_NUM_INSTRUCTS,
    localparam int PTR_W = $clog2(NUM_INSTRUCTS)
);

    // upstream instruction stream
    logic                     in_valid;
    logic [INSTRUCT_SIZE-1:0] in_data;
    logic                     in_ready;

    // instruction memory write port
    logic                     mem_we;
    logic [PTR_W-1:0]         mem_waddr;
    logic [INSTRUCT_SIZE-1:0] mem_wdata;

    // loader side: consumes the stream, drives the memory port
    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

    // environment side: produces the stream, observes the memory port
    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams instruction words into a contiguous instruction memory range
module imem_loader
    import imem_pkg::*;
#(
    parameter int INSTRUCT_SIZE = DEFAULT_INSTRUCT_SIZE,
    parameter int NUM_INSTRUCTS = DEFAULT_NUM_INSTRUCTS,
    localparam int PTR_W = $clog2(NUM_INSTRUCTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PTR_W-1:0]         base_addr,
    input  logic [PTR_W:0]           length,
    input  logic                     abort,
    imem_loader_if.master            bus,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [INSTRUCT_SIZE-1:0] checksum
);

    loader_state_t      state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W:0]     remaining;

    // end address is formed two bits wider than the pointer so it cannot wrap
    logic [PTR_W+1:0]   end_addr;
    logic               start_ok;
    logic               handshake;
    logic               last_word;

    // range check for a new request; rejects empty loads and overruns of the memory
    always_comb begin
        end_addr = {2'b00, base_addr} + {1'b0, length};
        start_ok = (length != '0) && (end_addr <= (PTR_W + 2)'(NUM_INSTRUCTS));
    end

    // loader accepts data only while loading and not being cancelled
    assign bus.in_ready = (state == LOAD) && !abort;
    assign handshake    = bus.in_valid && bus.in_ready;
    assign last_word    = (remaining == (PTR_W + 1)'(1));
    assign busy         = (state != IDLE);

    // control FSM with registered write port, status pulses and running checksum
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            checksum      <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            ptr       <= base_addr;
                            remaining <= length;
                            checksum  <= '0;
                            state     <= LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (abort) begin
                        // checksum and pointer are left as-is; only the FSM unwinds
                        state <= IDLE;
                        error <= 1'b1;
                    end else if (handshake) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_waddr <= ptr;
                        bus.mem_wdata <= bus.in_data;
                        checksum      <= checksum ^ bus.in_data;
                        remaining     <= remaining - (PTR_W + 1)'(1);
                        if (last_word) begin
                            // pointer stays on the last address so it never wraps past the top
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            ptr <= ptr + PTR_W'(1);
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int IS = 4;
    localparam int NI = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  length;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  checksum;

    imem_loader_if #(.INSTRUCT_SIZE(IS), .NUM_INSTRUCTS(NI)) bus ();

    imem_loader #(.INSTRUCT_SIZE(IS), .NUM_INSTRUCTS(NI)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt;
    int err_cnt;
    int we_cnt;
    bit busy_seen;

    logic [12:0] exp_q[$];

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  len;
        logic [7:0]  vpat;
        int          abort_after;
        logic [31:0] words;
        int          exp_err;
        int          exp_done;
        int          exp_we;
        logic [3:0]  exp_cks;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // scoreboard: every memory write must match the oldest predicted write
    always @(posedge clk) begin
        #2;
        if (bus.mem_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=no write",
                         bus.mem_waddr, bus.mem_wdata);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("write_addr", {23'd0, bus.mem_waddr}, {23'd0, e[12:4]});
                check("write_data", {28'd0, bus.mem_wdata}, {28'd0, e[3:0]});
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_with_write", {31'd0, bus.mem_we}, 32'd1);
            check("done_on_last_write", exp_q.size(), 32'd0);
        end
        if (error === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic clear_counts();
        done_cnt  = 0;
        err_cnt   = 0;
        we_cnt    = 0;
        busy_seen = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_mem_we"},   {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy}, 32'd0);
        check({tag, "_done"},     {31'd0, done}, 32'd0);
        check({tag, "_error"},    {31'd0, error}, 32'd0);
        check({tag, "_waddr"},    {23'd0, bus.mem_waddr}, 32'd0);
        check({tag, "_wdata"},    {28'd0, bus.mem_wdata}, 32'd0);
        check({tag, "_checksum"}, {28'd0, checksum}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [10:0] endp;
        bit          accept;
        logic [8:0]  ptr;
        logic [3:0]  d;
        int          hs;
        int          k;
        bit          vb;

        clear_counts();
        base_addr = v.base;
        length    = v.len;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        endp   = {2'b00, v.base} + {1'b0, v.len};
        accept = (v.len != 0) && (endp <= 11'd512);
        ptr    = v.base;
        if (accept) begin
            check($sformatf("v%0d_busy_after_start", idx), {31'd0, busy}, 32'd1);
            hs = 0;
            k  = 0;
            while (hs < int'(v.len) && k < 64) begin
                if (v.abort_after == hs) begin
                    abort        = 1'b1;
                    bus.in_valid = 1'b1;
                    bus.in_data  = 4'hE;
                    #1;
                    check($sformatf("v%0d_in_ready_abort", idx), {31'd0, bus.in_ready}, 32'd0);
                    @(posedge clk); #1;
                    abort        = 1'b0;
                    bus.in_valid = 1'b0;
                    break;
                end
                vb           = v.vpat[k % 8];
                d            = v.words[hs*4 +: 4];
                bus.in_valid = vb;
                bus.in_data  = d;
                #1;
                check($sformatf("v%0d_in_ready", idx), {31'd0, bus.in_ready}, 32'd1);
                if (vb) begin
                    exp_q.push_back({ptr, d});
                    ptr = ptr + 9'd1;
                    hs++;
                end
                k++;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
        end
        repeat (4) @(posedge clk);
        #3;
        check($sformatf("v%0d_done_count", idx), done_cnt, v.exp_done);
        check($sformatf("v%0d_error_count", idx), err_cnt, v.exp_err);
        check($sformatf("v%0d_write_count", idx), we_cnt, v.exp_we);
        check($sformatf("v%0d_checksum", idx), {28'd0, checksum}, {28'd0, v.exp_cks});
        check($sformatf("v%0d_busy_end", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_queue_empty", idx), exp_q.size(), 32'd0);
        if (!accept)
            check($sformatf("v%0d_busy_never", idx), {31'd0, busy_seen}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        base_addr    = '0;
        length       = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        clear_counts();

        //             base     len     vpat   abort words         err done we cks
        vecs[0] = '{9'd0,   10'd4, 8'hFF, -1, 32'h0000_8421, 0, 1, 4, 4'hF};
        vecs[1] = '{9'd10,  10'd3, 8'h15, -1, 32'h0000_03A5, 0, 1, 3, 4'hC};
        vecs[2] = '{9'd0,   10'd0, 8'hFF, -1, 32'h0000_0000, 1, 0, 0, 4'hC};
        vecs[3] = '{9'd510, 10'd3, 8'hFF, -1, 32'h0000_0000, 1, 0, 0, 4'hC};
        vecs[4] = '{9'd509, 10'd4, 8'hFF, -1, 32'h0000_0000, 1, 0, 0, 4'hC};
        vecs[5] = '{9'd508, 10'd4, 8'hFF, -1, 32'h0000_F731, 0, 1, 4, 4'hA};
        vecs[6] = '{9'd511, 10'd1, 8'hFF, -1, 32'h0000_0009, 0, 1, 1, 4'h9};
        vecs[7] = '{9'd100, 10'd5, 8'hFF,  2, 32'h0009_6C3B, 1, 0, 2, 4'h8};
        vecs[8] = '{9'd200, 10'd2, 8'hFF, -1, 32'h0000_0036, 0, 1, 2, 4'h5};

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // start issued while loading must not disturb pointer or remaining count
        clear_counts();
        base_addr = 9'd300; length = 10'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 4'h1; exp_q.push_back({9'd300, 4'h1});
        @(posedge clk); #1;
        base_addr = 9'd0; length = 10'd1; start = 1'b1;
        bus.in_data = 4'h2; exp_q.push_back({9'd301, 4'h2});
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_data = 4'h4; exp_q.push_back({9'd302, 4'h4});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("ign_done_count", done_cnt, 32'd1);
        check("ign_error_count", err_cnt, 32'd0);
        check("ign_write_count", we_cnt, 32'd3);
        check("ign_checksum", {28'd0, checksum}, 32'h7);
        check("ign_queue_empty", exp_q.size(), 32'd0);

        // reset in the middle of a load discards it silently
        clear_counts();
        base_addr = 9'd40; length = 10'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 4'h5; exp_q.push_back({9'd40, 4'h5});
        @(posedge clk); #1;
        bus.in_data = 4'h6; exp_q.push_back({9'd41, 4'h6});
        @(posedge clk); #1;
        reset = 1'b0; bus.in_data = 4'h7;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        reset = 1'b1; bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("midreset_done_count", done_cnt, 32'd0);
        check("midreset_error_count", err_cnt, 32'd0);
        check("midreset_write_count", we_cnt, 32'd2);
        check("midreset_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
